// File: rtl/term_writer.sv
// Byte-stream text terminal writing {attr,char} cells into the VGA screen RAM,
// with cursor, control codes, line wrap and scroll. Build macro: TERM_ATTR_ESC_EN (ESC loads attr).
module term_writer #(
  parameter int         COLS           = 132,
  parameter int         ROWS           = 30,
  parameter logic [7:0] DEFAULT_ATTR   = 8'h70,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic        mclk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [11:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic [7:0]  cur_col,
  output logic [4:0]  cur_row,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  localparam logic [11:0] TOTAL_M1  = 12'(COLS * ROWS - 1);
  localparam logic [11:0] COLS_W    = 12'(COLS);
  localparam logic [11:0] LAST_BASE = 12'(COLS * (ROWS - 1));
  localparam logic [7:0]  COL_MAX   = 8'(COLS - 1);
  localparam logic [4:0]  ROW_MAX   = 5'(ROWS - 1);

  typedef enum logic [2:0] {IDLE, PUT, SCR_RD, SCR_WR, CLR_LINE, CLR_ALL} state_t;

  state_t      state;
  logic [11:0] row_base;
  logic [11:0] cnt;
  logic [15:0] wdata_q;
  logic        scr_fwd;
  logic        scroll_pend;
  logic        esc_armed;
  logic [7:0]  attr;
  logic        in_fire;
  logic [11:0] cur_addr;

  // Handshake: a byte transfers on a posedge where in_valid && in_ready; in_ready
  // is a registered flag that is only high in IDLE, so the source holds the byte while busy.
  assign in_fire   = in_valid && in_ready;
  assign cur_addr  = row_base + {4'd0, cur_col};
  assign busy      = (state != IDLE);
  assign dbg_state = state;
  // Scroll write cycle forwards the cell read one cycle earlier straight from the RAM.
  assign mem_wdata = scr_fwd ? mem_rdata : wdata_q;

`ifdef TERM_ATTR_ESC_EN
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      esc_armed <= 1'b0;
      attr      <= DEFAULT_ATTR;
    end else if (in_fire) begin
      if (esc_armed) begin
        attr      <= in_data;
        esc_armed <= 1'b0;
      end else if (in_data == 8'h1B) begin
        esc_armed <= 1'b1;
      end
    end
  end
`else
  assign esc_armed = 1'b0;
  assign attr      = DEFAULT_ATTR;
`endif

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CLEAR_ON_RESET ? CLR_ALL : IDLE;
      in_ready    <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 12'd0;
      wdata_q     <= 16'd0;
      scr_fwd     <= 1'b0;
      cur_col     <= 8'd0;
      cur_row     <= 5'd0;
      row_base    <= 12'd0;
      cnt         <= 12'd0;
      scroll_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_fire && !esc_armed) begin
            if (in_data >= 8'h20) begin
              mem_we   <= 1'b1;
              mem_addr <= cur_addr;
              wdata_q  <= {attr, in_data};
              state    <= PUT;
              in_ready <= 1'b0;
              if (cur_col == COL_MAX) begin
                cur_col <= 8'd0;
                if (cur_row == ROW_MAX) begin
                  scroll_pend <= 1'b1;
                end else begin
                  cur_row  <= cur_row + 5'd1;
                  row_base <= row_base + COLS_W;
                end
              end else begin
                cur_col <= cur_col + 8'd1;
              end
            end else begin
              case (in_data)
                8'h0D: cur_col <= 8'd0;
                8'h08: if (cur_col != 8'd0) cur_col <= cur_col - 8'd1;
                8'h0A: begin
                  if (cur_row == ROW_MAX) begin
                    state    <= SCR_RD;
                    in_ready <= 1'b0;
                    mem_addr <= COLS_W;
                    cnt      <= COLS_W;
                  end else begin
                    cur_row  <= cur_row + 5'd1;
                    row_base <= row_base + COLS_W;
                  end
                end
                8'h0C: begin
                  state    <= CLR_ALL;
                  in_ready <= 1'b0;
                  mem_we   <= 1'b1;
                  mem_addr <= 12'd0;
                  cnt      <= 12'd0;
                  wdata_q  <= {attr, 8'h20};
                end
                default: ;
              endcase
            end
          end
        end
        PUT: begin
          mem_we <= 1'b0;
          if (scroll_pend) begin
            scroll_pend <= 1'b0;
            state       <= SCR_RD;
            mem_addr    <= COLS_W;
            cnt         <= COLS_W;
          end else begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end
        end
        SCR_RD: begin
          mem_addr <= cnt - COLS_W;
          mem_we   <= 1'b1;
          scr_fwd  <= 1'b1;
          state    <= SCR_WR;
        end
        SCR_WR: begin
          scr_fwd <= 1'b0;
          if (cnt == TOTAL_M1) begin
            state    <= CLR_LINE;
            mem_addr <= LAST_BASE;
            cnt      <= LAST_BASE;
            wdata_q  <= {attr, 8'h20};
          end else begin
            mem_we   <= 1'b0;
            cnt      <= cnt + 12'd1;
            mem_addr <= cnt + 12'd1;
            state    <= SCR_RD;
          end
        end
        CLR_LINE: begin
          if (cnt == TOTAL_M1) begin
            mem_we   <= 1'b0;
            state    <= IDLE;
            in_ready <= 1'b1;
          end else begin
            cnt      <= cnt + 12'd1;
            mem_addr <= cnt + 12'd1;
          end
        end
        CLR_ALL: begin
          // Entered from reset with the strobe low: spend one cycle arming the first write.
          if (!mem_we) begin
            mem_we   <= 1'b1;
            mem_addr <= 12'd0;
            cnt      <= 12'd0;
            wdata_q  <= {attr, 8'h20};
          end else if (cnt == TOTAL_M1) begin
            mem_we   <= 1'b0;
            state    <= IDLE;
            in_ready <= 1'b1;
            cur_col  <= 8'd0;
            cur_row  <= 5'd0;
            row_base <= 12'd0;
          end else begin
            cnt      <= cnt + 12'd1;
            mem_addr <= cnt + 12'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_term_writer.sv
// Bench for term_writer: behavioural screen RAM, expected-write queue checked by a
// negedge monitor, directed byte sequences for clear, put, control codes, wrap, scroll and reset.
module tb_term_writer;
  localparam int COLS = 132;
  localparam int ROWS = 30;
  localparam int TOT  = COLS * ROWS;

  // clock / reset
  logic mclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 mclk = ~mclk;

  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic [7:0]  cur_col;
  logic [4:0]  cur_row;
  logic        busy;
  logic [2:0]  dbg_state;

  term_writer dut (
    .mclk(mclk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .cur_col(cur_col), .cur_row(cur_row), .busy(busy), .dbg_state(dbg_state)
  );

  // screen RAM, 1-cycle read latency
  logic [15:0] ram [0:4095];
  always @(posedge mclk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // scoreboard
  logic [27:0] exp_q[$];
  logic [15:0] exp_scr [0:TOT-1];
  logic [27:0] mon_e;
  int checks = 0;
  int failures = 0;
  int we_cnt = 0;
  int m_col = 0;
  int m_row = 0;
  logic [7:0] m_attr = 8'h70;

  always @(negedge mclk) begin
    if (rst_n && mem_we) begin
      we_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL mem_write unexpected addr=%0d data=%h", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== mon_e) begin
          failures++;
          $display("FAIL mem_write got addr=%0d data=%h want addr=%0d data=%h",
                   mem_addr, mem_wdata, mon_e[27:16], mon_e[15:0]);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < 20000) begin
      @(negedge mclk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout byte=%h", b);
    end
    in_data  = b;
    in_valid = 1'b1;
    @(posedge mclk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_ready(input int max_cyc, output int n);
    n = 0;
    @(negedge mclk);
    while (!in_ready && n < max_cyc) begin
      n++;
      @(negedge mclk);
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout got=%0d cycles want<=%0d", n, max_cyc);
    end
  endtask

  task automatic put_char(input logic [7:0] b);
    int n;
    int a;
    a = m_row * COLS + m_col;
    exp_q.push_back({12'(a), m_attr, b});
    exp_scr[a] = {m_attr, b};
    send(b);
    wait_ready(10, n);
    chk("put_latency", n, 1);
    m_col++;
    if (m_col == COLS) begin
      m_col = 0;
      if (m_row < ROWS - 1) m_row++;
    end
  endtask

  task automatic ctrl(input logic [7:0] b);
    int n;
    int snap;
    snap = we_cnt;
    send(b);
    wait_ready(10, n);
    chk("ctrl_no_write", we_cnt - snap, 0);
  endtask

  task automatic push_clear_all();
    for (int i = 0; i < TOT; i++) begin
      exp_q.push_back({12'(i), m_attr, 8'h20});
      exp_scr[i] = {m_attr, 8'h20};
    end
  endtask

  task automatic push_scroll();
    for (int a = COLS; a < TOT; a++) begin
      exp_q.push_back({12'(a - COLS), exp_scr[a]});
      exp_scr[a - COLS] = exp_scr[a];
    end
    for (int a = TOT - COLS; a < TOT; a++) begin
      exp_q.push_back({12'(a), m_attr, 8'h20});
      exp_scr[a] = {m_attr, 8'h20};
    end
  endtask

  task automatic chk_cursor(input string name);
    chk({name, "_col"}, cur_col, m_col);
    chk({name, "_row"}, cur_row, m_row);
  endtask

  initial begin
    int n;
    // reset state and power-up clear
    repeat (3) @(negedge mclk);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_col", cur_col, 0);
    chk("rst_row", cur_row, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 1);
    push_clear_all();
    rst_n = 1'b1;
    wait_ready(5000, n);
    chk("clear_drain", exp_q.size(), 0);
    chk_cursor("clear_home");

    // 'A' at (0,0): strobe one cycle after acceptance, ready again after two
    exp_q.push_back({12'd0, 16'h7041});
    exp_scr[0] = 16'h7041;
    send(8'h41);
    @(negedge mclk);
    chk("a_we_first", mem_we, 1);
    chk("a_ready_low", in_ready, 0);
    @(negedge mclk);
    chk("a_we_once", mem_we, 0);
    chk("a_ready_back", in_ready, 1);
    m_col = 1;
    chk_cursor("a_cursor");

    // CR, BS at col 0, BEL, BS at col 5
    ctrl(8'h0D); m_col = 0; chk("cr_col", cur_col, 0);
    ctrl(8'h08); chk("bs0_col", cur_col, 0);
    ctrl(8'h07); chk("bel_col", cur_col, 0);
    for (int i = 0; i < 5; i++) put_char(8'h62 + 8'(i));
    chk("five_col", cur_col, 5);
    ctrl(8'h08); m_col = 4; chk("bs5_col", cur_col, 4);

    // move to (131,29) without scrolling
    ctrl(8'h0D); m_col = 0;
    for (int i = 0; i < ROWS - 1; i++) ctrl(8'h0A);
    m_row = ROWS - 1;
    chk_cursor("lf_bottom");
    for (int i = 0; i < COLS - 1; i++) put_char(8'h30 + 8'(i % 10));
    chk_cursor("row_end");

    // wrap-to-scroll: write at 3959, scroll, blank last row, cursor (0,29)
    exp_q.push_back({12'd3959, 16'h7042});
    exp_scr[3959] = 16'h7042;
    push_scroll();
    send(8'h42);
    wait_ready(20000, n);
    chk("scroll_busy_cycles", n, 1 + 2 * COLS * (ROWS - 1) + COLS);
    chk("scroll_drain", exp_q.size(), 0);
    m_col = 0;
    chk_cursor("scroll_cursor");

    // ESC handling
`ifdef TERM_ATTR_ESC_EN
    ctrl(8'h1B);
    ctrl(8'h1E);
    m_attr = 8'h1E;
    put_char(8'h78);
`else
    ctrl(8'h1B);
    chk("esc_col", cur_col, 0);
    put_char(8'h78);
`endif
    chk("esc_drain", exp_q.size(), 0);

    // reset in the middle of an LF-driven scroll
    push_scroll();
    send(8'h0A);
    repeat (40) @(negedge mclk);
    n = 0;
    @(posedge mclk); #2;
    while (!mem_we && n < 10) begin
      @(posedge mclk); #2;
      n++;
    end
    chk("mid_scroll_we", mem_we, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_we", mem_we, 0);
    chk("abort_addr", mem_addr, 0);
    chk("abort_col", cur_col, 0);
    chk("abort_row", cur_row, 0);
    chk("abort_ready", in_ready, 0);
    exp_q.delete();
    m_attr = 8'h70;
    m_col = 0;
    m_row = 0;
    push_clear_all();
    @(negedge mclk);
    rst_n = 1'b1;
    wait_ready(5000, n);
    chk("reclear_drain", exp_q.size(), 0);
    chk_cursor("reclear_home");

    // printable wrap on a non-final row
    for (int i = 0; i < COLS; i++) put_char(8'h41 + 8'(i % 26));
    chk_cursor("wrap_row1");

    // form feed clears everything and homes the cursor
    push_clear_all();
    m_col = 0;
    m_row = 0;
    send(8'h0C);
    wait_ready(5000, n);
    chk("ff_busy_cycles", n, TOT);
    chk("ff_drain", exp_q.size(), 0);
    chk_cursor("ff_home");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
